// File: rtl/admo_ex_stage_pkg.sv
// Shared constants for the execute stage: data width and ALU op codes.
// Also provides the op-code legality check used by the stage.
package admo_ex_stage_pkg;

   localparam int DATA_WIDTH = 32;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;

   function automatic logic alu_op_legal(input logic [3:0] op);
      return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
             (op == ALU_OR)  || (op == ALU_XOR);
   endfunction

endpackage

// File: rtl/admo_alu.sv
// Combinational ALU. Arithmetic wraps modulo 2^DATA_WIDTH; carry is discarded.
module admo_alu
   import admo_ex_stage_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] alu_a,
   input  logic [DATA_WIDTH-1:0] alu_b,
   input  logic [3:0]            alu_op,
   output logic [DATA_WIDTH-1:0] alu_y
);

   always_comb begin
      alu_y = '0;
      case (alu_op)
         ALU_ADD: alu_y = alu_a + alu_b;
         ALU_SUB: alu_y = alu_a - alu_b;
         ALU_AND: alu_y = alu_a & alu_b;
         ALU_OR:  alu_y = alu_a | alu_b;
         ALU_XOR: alu_y = alu_a ^ alu_b;
         default: alu_y = '0;
      endcase
   end

endmodule

// File: rtl/admo_ex_stage.sv
// Execute stage: forwarding and operand muxes, ALU, and a single output register
// bank toward memory with a valid/ready handshake on both sides.
module admo_ex_stage
   import admo_ex_stage_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int FWD_EN = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  id_valid,
   output logic                  id_ready,
   input  logic [3:0]            id_alu_op,
   input  logic [REG_AW-1:0]     id_rs1_addr,
   input  logic [REG_AW-1:0]     id_rs2_addr,
   input  logic [DATA_WIDTH-1:0] id_rs1_data,
   input  logic [DATA_WIDTH-1:0] id_rs2_data,
   input  logic [DATA_WIDTH-1:0] id_imm,
   input  logic [DATA_WIDTH-1:0] id_pc,
   input  logic                  id_use_imm,
   input  logic                  id_use_pc,
   input  logic [REG_AW-1:0]     id_rd,
   input  logic                  id_rd_we,
   input  logic                  wb_we,
   input  logic [REG_AW-1:0]     wb_rd,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  ex_valid,
   input  logic                  mem_ready,
   output logic [DATA_WIDTH-1:0] ex_result,
   output logic [REG_AW-1:0]     ex_rd,
   output logic                  ex_rd_we,
   output logic                  ex_zero,
   output logic                  ex_illegal
);

   logic                  ex_valid_q,  ex_valid_d;
   logic [DATA_WIDTH-1:0] ex_result_q, ex_result_d;
   logic [REG_AW-1:0]     ex_rd_q,     ex_rd_d;
   logic                  ex_rd_we_q,  ex_rd_we_d;
   logic                  ex_zero_q,   ex_zero_d;
   logic                  ex_illegal_q, ex_illegal_d;

   logic                  accept;
   logic                  op_legal;
   logic [DATA_WIDTH-1:0] op_a, op_b, alu_y;

   logic [REG_AW-1:0]     rs_addr  [2];
   logic [DATA_WIDTH-1:0] rs_data  [2];
   logic [DATA_WIDTH-1:0] fwd_data [2];

   assign rs_addr[0] = id_rs1_addr;
   assign rs_addr[1] = id_rs2_addr;
   assign rs_data[0] = id_rs1_data;
   assign rs_data[1] = id_rs2_data;

   // x0 is never forwarded; the held EX result outranks the writeback port.
   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic ex_hit, wb_hit;
      assign ex_hit = (FWD_EN != 0) && (rs_addr[gi] != '0) && ex_valid_q &&
                      ex_rd_we_q && (ex_rd_q == rs_addr[gi]);
      assign wb_hit = (FWD_EN != 0) && (rs_addr[gi] != '0) && wb_we &&
                      (wb_rd == rs_addr[gi]);
      assign fwd_data[gi] = ex_hit ? ex_result_q :
                            wb_hit ? wb_data     : rs_data[gi];
   end

   assign op_a     = id_use_pc  ? id_pc  : fwd_data[0];
   assign op_b     = id_use_imm ? id_imm : fwd_data[1];
   assign op_legal = alu_op_legal(id_alu_op);

   admo_alu u_alu (
      .alu_a  (op_a),
      .alu_b  (op_b),
      .alu_op (id_alu_op),
      .alu_y  (alu_y)
   );

   assign id_ready = flush | ~ex_valid_q | mem_ready;
   assign accept   = id_valid & id_ready & ~flush;

   always_comb begin
      ex_valid_d   = ex_valid_q;
      ex_result_d  = ex_result_q;
      ex_rd_d      = ex_rd_q;
      ex_rd_we_d   = ex_rd_we_q;
      ex_zero_d    = ex_zero_q;
      ex_illegal_d = ex_illegal_q;
      if (flush) begin
         ex_valid_d = 1'b0;
      end else if (accept) begin
         ex_valid_d   = 1'b1;
         ex_result_d  = op_legal ? alu_y : '0;
         ex_rd_d      = id_rd;
         ex_rd_we_d   = id_rd_we & op_legal & (id_rd != '0);
         ex_zero_d    = op_legal ? (alu_y == '0) : 1'b1;
         ex_illegal_d = ~op_legal;
      end else if (mem_ready) begin
         ex_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q   <= 1'b0;
         ex_result_q  <= '0;
         ex_rd_q      <= '0;
         ex_rd_we_q   <= 1'b0;
         ex_zero_q    <= 1'b0;
         ex_illegal_q <= 1'b0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_result_q  <= ex_result_d;
         ex_rd_q      <= ex_rd_d;
         ex_rd_we_q   <= ex_rd_we_d;
         ex_zero_q    <= ex_zero_d;
         ex_illegal_q <= ex_illegal_d;
      end
   end

   assign ex_valid   = ex_valid_q;
   assign ex_result  = ex_result_q;
   assign ex_rd      = ex_rd_q;
   assign ex_rd_we   = ex_rd_we_q;
   assign ex_zero    = ex_zero_q;
   assign ex_illegal = ex_illegal_q;

endmodule
